// File: rtl/tdm_mux_array_if.sv
// Config write port of tdm_mux_array: valid/ready handshake plus error pulse.
// CH_W defaults to the channel-index width; a wider CH_W lets a master address out-of-range channels.
interface tdm_mux_array_if #(
    parameter int unsigned NCH  = 16,
    parameter int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1
);
    logic            cfg_valid;
    logic            cfg_ready;
    logic [CH_W-1:0] cfg_ch;
    logic [1:0]      cfg_mode;
    logic            cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/tdm_mux_array.sv
// Framed TDM packer: per channel, pass/TDM/low/high onto one pin; modes change only at frame boundaries.
// Define MUX_INPUT_FILTER_EN to add a 2-flop synchroniser and 3-sample majority filter on da/db.
module tdm_mux_array #(
    parameter int unsigned NCH      = 16,
    parameter int unsigned SLOT_DIV = 4,
    parameter logic [1:0]  MODE_RST = 2'b01
) (
    input  logic            clk_sys,
    input  logic            rst,
    input  logic [NCH-1:0]  da,
    input  logic [NCH-1:0]  db,
    tdm_mux_array_if.slave  cfg,
    output logic            frame_sync,
    output logic [NCH-1:0]  mux
);
    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_TDM  = 2'b01,
        MODE_LOW  = 2'b10,
        MODE_HIGH = 2'b11
    } mode_e;

    localparam mode_e      MODE_RST_E = mode_e'(MODE_RST);
    localparam logic [7:0] CNT_LAST   = 8'(SLOT_DIV - 1);

    logic [7:0]     slot_cnt_q, slot_cnt_d;
    logic [1:0]     slot_idx_q, slot_idx_d;
    logic [NCH-1:0] cap_a_q, cap_a_d, cap_b_q, cap_b_d;
    mode_e          mode_q [NCH];
    mode_e          mode_d [NCH];
    logic           pending_q, pending_d;
    logic [NCH-1:0] pend_sel_q, pend_sel_d;
    mode_e          pend_mode_q, pend_mode_d;
    logic           err_q, err_d;
    logic           fs_q, fs_d;
    logic [NCH-1:0] mux_q, mux_d;

    logic [NCH-1:0] src_a, src_b, sel;
    logic           boundary, accept, in_range;

`ifdef MUX_INPUT_FILTER_EN
    logic [NCH-1:0] a_s1_q, a_s2_q, a_h0_q, a_h1_q;
    logic [NCH-1:0] b_s1_q, b_s2_q, b_h0_q, b_h1_q;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            a_s1_q <= '0; a_s2_q <= '0; a_h0_q <= '0; a_h1_q <= '0;
            b_s1_q <= '0; b_s2_q <= '0; b_h0_q <= '0; b_h1_q <= '0;
        end else begin
            a_s1_q <= da;     a_s2_q <= a_s1_q; a_h0_q <= a_s2_q; a_h1_q <= a_h0_q;
            b_s1_q <= db;     b_s2_q <= b_s1_q; b_h0_q <= b_s2_q; b_h1_q <= b_h0_q;
        end
    end

    // Majority over the newest synchronised sample and the two before it.
    assign src_a = (a_s2_q & a_h0_q) | (a_s2_q & a_h1_q) | (a_h0_q & a_h1_q);
    assign src_b = (b_s2_q & b_h0_q) | (b_s2_q & b_h1_q) | (b_h0_q & b_h1_q);
`else
    assign src_a = da;
    assign src_b = db;
`endif

    always_comb begin
        boundary = (slot_idx_q == 2'd3) && (slot_cnt_q == CNT_LAST);
        accept   = cfg.cfg_valid & ~pending_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            sel[i] = (32'(cfg.cfg_ch) == i);
        end
        in_range = |sel;

        slot_cnt_d  = slot_cnt_q;
        slot_idx_d  = slot_idx_q;
        cap_a_d     = cap_a_q;
        cap_b_d     = cap_b_q;
        mode_d      = mode_q;
        pending_d   = pending_q;
        pend_sel_d  = pend_sel_q;
        pend_mode_d = pend_mode_q;
        err_d       = accept & ~in_range;
        fs_d        = boundary;
        mux_d       = '0;

        if (boundary) begin
            slot_cnt_d = '0;
            slot_idx_d = '0;
        end else if (slot_cnt_q == CNT_LAST) begin
            slot_cnt_d = '0;
            slot_idx_d = slot_idx_q + 2'd1;
        end else begin
            slot_cnt_d = slot_cnt_q + 8'd1;
        end

        // A write accepted on the boundary edge bypasses the pending slot entirely.
        if (boundary) begin
            cap_a_d   = src_a;
            cap_b_d   = src_b;
            pending_d = 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (pending_q && pend_sel_q[i]) mode_d[i] = pend_mode_q;
                if (accept && sel[i])           mode_d[i] = mode_e'(cfg.cfg_mode);
            end
        end else if (accept && in_range) begin
            pending_d   = 1'b1;
            pend_sel_d  = sel;
            pend_mode_d = mode_e'(cfg.cfg_mode);
        end

        for (int unsigned i = 0; i < NCH; i++) begin
            unique case (mode_d[i])
                MODE_PASS: mux_d[i] = src_a[i];
                MODE_TDM: begin
                    unique case (slot_idx_d)
                        2'd0:    mux_d[i] = 1'b1;
                        2'd1:    mux_d[i] = cap_a_d[i];
                        2'd2:    mux_d[i] = cap_b_d[i];
                        default: mux_d[i] = 1'b0;
                    endcase
                end
                MODE_LOW:  mux_d[i] = 1'b0;
                MODE_HIGH: mux_d[i] = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            slot_cnt_q  <= CNT_LAST;
            slot_idx_q  <= 2'd3;
            cap_a_q     <= '0;
            cap_b_q     <= '0;
            pending_q   <= 1'b0;
            pend_sel_q  <= '0;
            pend_mode_q <= MODE_RST_E;
            err_q       <= 1'b0;
            fs_q        <= 1'b0;
            mux_q       <= '0;
            for (int unsigned i = 0; i < NCH; i++) mode_q[i] <= MODE_RST_E;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            slot_idx_q  <= slot_idx_d;
            cap_a_q     <= cap_a_d;
            cap_b_q     <= cap_b_d;
            pending_q   <= pending_d;
            pend_sel_q  <= pend_sel_d;
            pend_mode_q <= pend_mode_d;
            err_q       <= err_d;
            fs_q        <= fs_d;
            mux_q       <= mux_d;
            mode_q      <= mode_d;
        end
    end

    assign cfg.cfg_ready = ~pending_q;
    assign cfg.cfg_err   = err_q;
    assign frame_sync    = fs_q;
    assign mux           = mux_q;
endmodule

// File: tb/tb_tdm_mux_array.sv
// Randomised bench for tdm_mux_array against a frame-position reference model.
module tb_tdm_mux_array;
    localparam int NCH   = 16;
    localparam int SD    = 4;
    localparam int FRAME = 4 * SD;

    logic           clk_sys = 1'b0;
    logic           rst     = 1'b1;
    logic [NCH-1:0] da      = '0;
    logic [NCH-1:0] db      = '0;
    logic           frame_sync;
    logic [NCH-1:0] mux;

    // 5-bit channel field so channel 20 can be addressed.
    tdm_mux_array_if #(.NCH(NCH), .CH_W(5)) cfg_if ();

    tdm_mux_array #(.NCH(NCH), .SLOT_DIV(SD), .MODE_RST(2'b01)) dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .da         (da),
        .db         (db),
        .cfg        (cfg_if),
        .frame_sync (frame_sync),
        .mux        (mux)
    );

    always #5 clk_sys = ~clk_sys;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: frame position is the edge count since reset release modulo FRAME.
    int             ecount;
    logic [1:0]     m_mode [NCH];
    logic [NCH-1:0] cap_a, cap_b, m_mux;
    logic           m_fs, m_err, m_pend;
    int             m_pch;
    logic [1:0]     m_pmode;

    task automatic tick();
        bit acc, inr, bnd;
        int slot;
        @(posedge clk_sys);
        if (rst) begin
            ecount = 0; m_mux = '0; m_fs = 0; m_err = 0; m_pend = 0;
            cap_a = '0; cap_b = '0;
            for (int c = 0; c < NCH; c++) m_mode[c] = 2'b01;
        end else begin
            bnd   = (ecount % FRAME) == 0;
            acc   = cfg_if.cfg_valid && !m_pend;
            inr   = int'(cfg_if.cfg_ch) < NCH;
            m_err = acc && !inr;
            if (bnd) begin
                cap_a = da;
                cap_b = db;
                if (m_pend) m_mode[m_pch] = m_pmode;
                if (acc && inr) m_mode[int'(cfg_if.cfg_ch)] = cfg_if.cfg_mode;
                m_pend = 0;
            end else if (acc && inr) begin
                m_pend  = 1;
                m_pch   = int'(cfg_if.cfg_ch);
                m_pmode = cfg_if.cfg_mode;
            end
            m_fs = bnd;
            slot = (ecount % FRAME) / SD;
            for (int c = 0; c < NCH; c++) begin
                case (m_mode[c])
                    2'b00:   m_mux[c] = da[c];
                    2'b01:   m_mux[c] = (slot == 0) ? 1'b1 : (slot == 1) ? cap_a[c] :
                                        (slot == 2) ? cap_b[c] : 1'b0;
                    2'b10:   m_mux[c] = 1'b0;
                    default: m_mux[c] = 1'b1;
                endcase
            end
            ecount++;
        end
        #1;
    endtask

    task automatic drive_cfg(input bit v, input int ch, input logic [1:0] md);
        cfg_if.cfg_valid = v;
        cfg_if.cfg_ch    = 5'(ch);
        cfg_if.cfg_mode  = md;
    endtask

    task automatic test_reset();
        rst = 1;
        drive_cfg(0, 0, 2'b00);
        da = 16'($urandom);
        db = 16'($urandom);
        repeat (3) tick();
        vectors++; if (mux !== '0)         begin miscompares++; $display("FAIL reset_mux got=%h exp=0000", mux); end
        vectors++; if (frame_sync !== 1'b0) begin miscompares++; $display("FAIL reset_fs got=%b exp=0", frame_sync); end
        vectors++; if (cfg_if.cfg_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", cfg_if.cfg_err); end
        vectors++; if (cfg_if.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", cfg_if.cfg_ready); end
    endtask

    task automatic test_release();
        da = 16'($urandom); da[3] = 1'b1;
        db = 16'($urandom); db[3] = 1'b0;
        rst = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            tick();
            vectors++; if (mux !== m_mux) begin miscompares++; $display("FAIL rel_mux k=%0d got=%h exp=%h", k, mux, m_mux); end
            vectors++; if (frame_sync !== ((k % FRAME) == 0)) begin miscompares++; $display("FAIL rel_fs k=%0d got=%b exp=%b", k, frame_sync, (k % FRAME) == 0); end
            vectors++; if (mux[3] !== ((k % FRAME) < 2 * SD)) begin miscompares++; $display("FAIL rel_ch3 k=%0d got=%b exp=%b", k, mux[3], (k % FRAME) < 2 * SD); end
            da = 16'($urandom); da[3] = 1'b1;
            db = 16'($urandom); db[3] = 1'b0;
        end
    endtask

    task automatic test_mid_write();
        bit seen = 0;
        while ((ecount % FRAME) != 6) tick();
        drive_cfg(1, 5, 2'b11);
        tick();
        drive_cfg(0, 0, 2'b00);
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (k > 0) tick();
            if (((ecount - 1) % FRAME) == 0) seen = 1;
            vectors++; if (mux !== m_mux) begin miscompares++; $display("FAIL mid_mux k=%0d got=%h exp=%h", k, mux, m_mux); end
            vectors++; if (cfg_if.cfg_ready !== seen) begin miscompares++; $display("FAIL mid_ready k=%0d got=%b exp=%b", k, cfg_if.cfg_ready, seen); end
            if (seen) begin
                vectors++; if (mux[5] !== 1'b1) begin miscompares++; $display("FAIL mid_ch5 k=%0d got=%b exp=1", k, mux[5]); end
            end
            da = 16'($urandom);
            db = 16'($urandom);
        end
    endtask

    task automatic test_coincident();
        while ((ecount % FRAME) != 0) tick();
        drive_cfg(1, 2, 2'b10);
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (k == 0) drive_cfg(0, 0, 2'b00);
            vectors++; if (mux !== m_mux) begin miscompares++; $display("FAIL coin_mux k=%0d got=%h exp=%h", k, mux, m_mux); end
            vectors++; if (mux[2] !== 1'b0) begin miscompares++; $display("FAIL coin_ch2 k=%0d got=%b exp=0", k, mux[2]); end
            vectors++; if (cfg_if.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL coin_ready k=%0d got=%b exp=1", k, cfg_if.cfg_ready); end
            da = 16'($urandom);
            db = 16'($urandom);
        end
    endtask

    task automatic test_cfg_err();
        while ((ecount % FRAME) != 9) tick();
        drive_cfg(1, 20, 2'b11);
        tick();
        drive_cfg(0, 0, 2'b00);
        vectors++; if (cfg_if.cfg_err !== 1'b1) begin miscompares++; $display("FAIL err_pulse got=%b exp=1", cfg_if.cfg_err); end
        vectors++; if (cfg_if.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL err_ready got=%b exp=1", cfg_if.cfg_ready); end
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            vectors++; if (cfg_if.cfg_err !== 1'b0) begin miscompares++; $display("FAIL err_clear k=%0d got=%b exp=0", k, cfg_if.cfg_err); end
            vectors++; if (mux !== m_mux) begin miscompares++; $display("FAIL err_mux k=%0d got=%h exp=%h", k, mux, m_mux); end
            vectors++; if ({mux[5], mux[2]} !== 2'b10) begin miscompares++; $display("FAIL err_modes k=%0d got=%b exp=10", k, {mux[5], mux[2]}); end
            da = 16'($urandom);
            db = 16'($urandom);
        end
    endtask

    task automatic test_pass();
        logic d0;
        while ((ecount % FRAME) != 5) tick();
        drive_cfg(1, 0, 2'b00);
        tick();
        drive_cfg(0, 0, 2'b00);
        while ((ecount % FRAME) != 1) tick();
        d0 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            d0 = ~d0;
            da = 16'($urandom);
            da[0] = d0;
            db = 16'($urandom);
            tick();
            vectors++; if (mux[0] !== d0) begin miscompares++; $display("FAIL pass_ch0 k=%0d got=%b exp=%b", k, mux[0], d0); end
            vectors++; if (mux !== m_mux) begin miscompares++; $display("FAIL pass_mux k=%0d got=%h exp=%h", k, mux, m_mux); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300 + FRAME + 1; k++) begin
            da = 16'($urandom);
            db = 16'($urandom);
            if (k < 300) drive_cfg(($urandom % 4) == 0, $urandom_range(0, 20), 2'($urandom));
            else         drive_cfg(0, 0, 2'b00);
            tick();
            vectors++; if (mux !== m_mux) begin miscompares++; $display("FAIL rnd_mux k=%0d got=%h exp=%h", k, mux, m_mux); end
            vectors++; if (frame_sync !== m_fs) begin miscompares++; $display("FAIL rnd_fs k=%0d got=%b exp=%b", k, frame_sync, m_fs); end
            vectors++; if (cfg_if.cfg_err !== m_err) begin miscompares++; $display("FAIL rnd_err k=%0d got=%b exp=%b", k, cfg_if.cfg_err, m_err); end
            vectors++; if (cfg_if.cfg_ready !== !m_pend) begin miscompares++; $display("FAIL rnd_ready k=%0d got=%b exp=%b", k, cfg_if.cfg_ready, !m_pend); end
        end
    endtask

    task automatic test_reset_mid();
        while ((ecount % FRAME) != 8) tick();
        drive_cfg(1, 7, 2'b10);
        tick();
        drive_cfg(0, 0, 2'b00);
        tick();
        vectors++; if (cfg_if.cfg_ready !== 1'b0) begin miscompares++; $display("FAIL rstm_pending got=%b exp=0", cfg_if.cfg_ready); end
        rst = 1;
        tick();
        vectors++; if (mux !== '0) begin miscompares++; $display("FAIL rstm_mux got=%h exp=0000", mux); end
        vectors++; if (cfg_if.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL rstm_ready got=%b exp=1", cfg_if.cfg_ready); end
        vectors++; if ({frame_sync, cfg_if.cfg_err} !== 2'b00) begin miscompares++; $display("FAIL rstm_fs_err got=%b exp=00", {frame_sync, cfg_if.cfg_err}); end
        rst = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            if (k == 0) begin
                vectors++; if (mux !== '1) begin miscompares++; $display("FAIL rstm_start got=%h exp=ffff", mux); end
            end
            vectors++; if (mux !== m_mux) begin miscompares++; $display("FAIL rstm_mux2 k=%0d got=%h exp=%h", k, mux, m_mux); end
            vectors++; if (cfg_if.cfg_err !== 1'b0) begin miscompares++; $display("FAIL rstm_err k=%0d got=%b exp=0", k, cfg_if.cfg_err); end
            vectors++; if (mux[7] !== ((k % FRAME) < SD ? 1'b1 : (k % FRAME) < 2 * SD ? cap_a[7] : (k % FRAME) < 3 * SD ? cap_b[7] : 1'b0)) begin
                miscompares++; $display("FAIL rstm_ch7 k=%0d got=%b", k, mux[7]);
            end
            da = 16'($urandom);
            db = 16'($urandom);
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_mid_write();
        test_coincident();
        test_cfg_err();
        test_pass();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tdm_mux_array.md
# tdm_mux_array

Parametrised, time-division-multiplexed successor to the fixed 16-channel mux array. It packs two panel timing sources (`da`, `db`) per channel onto a single output pin as a framed serial pattern. Each channel has a mode that is runtime-programmable through a valid/ready config port: pass-through, TDM, force-low or force-high. The block sits between the timing generator (STV/CKV/CKH/GRST/GAS sources) and the board-level level-shifter pins.

## Interface
Parameters:
- `NCH`, 16: channel count, 1..64.
- `SLOT_DIV`, 4: `clk_sys` cycles per slot, 2..255.
- `MODE_RST`, 2'b01: reset mode of every channel.

Ports:
- `clk_sys`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous and active-high.
- `da`  in  NCH  source A, one bit per channel.
- `db`  in  NCH  source B, one bit per channel.
- `cfg_valid`  in  1  config write request.
- `cfg_ready`  out  1  config write can be accepted.
- `cfg_ch`  in  $clog2(NCH) (minimum 1)  target channel.
- `cfg_mode`  in  2  mode code: 00 pass, 01 TDM, 10 low, 11 high.
- `cfg_err`  out  1  one-cycle pulse when a write targets `cfg_ch`≥NCH.
- `frame_sync`  out  1  one-cycle pulse on the first cycle of each frame.
- `mux`  out  NCH  multiplexed outputs.

## Operation
- Shared timebase:
  - `slot_cnt` runs 0..SLOT_DIV-1; `slot_idx` runs 0..3.
  - One frame is 4 slots, i.e. 4·SLOT_DIV cycles.
- Frame boundary: the edge that leaves the last cycle of slot 3. At that edge the block:
  - captures `da` and `db` into `cap_a` and `cap_b`;
  - applies any pending mode write;
  - drives slot-0 values onto `mux`.
- TDM slot values per channel:
  - slot 0 = 1 (start);
  - slot 1 = `cap_a`;
  - slot 2 = `cap_b`;
  - slot 3 = 0 (stop).
- Mode behaviour:
  - Pass: `mux[i]` is registered `da[i]`, independent of the frame.
  - Low: `mux[i]` is 0. High: `mux[i]` is 1.
  - A new mode takes effect only at a frame boundary.
- Config handshake:
  - A write is accepted on an edge with `cfg_valid & cfg_ready`.
  - `cfg_ready = ~pending`. The pending register is one entry deep.
  - An accepted write sets `pending`. It is applied at the next boundary, and `cfg_ready` returns high the cycle after that boundary.
  - If acceptance and a boundary occur on the same edge, the write is applied immediately, `pending` stays 0, and the mode is effective for the frame starting at that edge.
- Out-of-range `cfg_ch`: the write is accepted, no state changes, `pending` is not set, and `cfg_err` pulses for one cycle after the accept edge.

## Timing
- Reset values:
  - `mux` = 0, `frame_sync` = 0, `cfg_err` = 0, `cfg_ready` = 1.
  - `pending` = 0; all modes = `MODE_RST`.
  - Counters are held at the terminal cycle (`slot_idx`=3, `slot_cnt`=SLOT_DIV-1).
- The first edge with `rst` low is a frame boundary:
  - `frame_sync` and the slot-0 values appear in the cycle after it;
  - `da`/`db` are captured at that same edge.
- `frame_sync` period is 4·SLOT_DIV cycles.
- Each TDM slot value holds for exactly SLOT_DIV cycles.
- `da`/`db` changes that occur mid-frame are invisible until the next capture.
- Pass-mode latency is 1 cycle (without filter).
- Reset asserted mid-frame: on the next edge, outputs and counters return to their reset values and any pending write is discarded.
- All outputs are registered; there are no combinational input-to-output paths.
- `cfg_ready` depends only on registered state.

## Configuration
- `MUX_INPUT_FILTER_EN` defined:
  - `da` and `db` each pass through a 2-flop synchroniser and then a 3-sample majority filter.
  - Pass-mode latency becomes 4 cycles.
  - TDM capture uses the filtered values.
  - An isolated 1-cycle glitch is rejected.
  - Filter registers reset to 0.
- Not defined: inputs are used directly, and pass-mode latency is 1 cycle.

## Test plan
All scenarios use NCH=16, SLOT_DIV=4, filter off unless noted.
- Reset release with MODE_RST=01, `da[3]`=1, `db[3]`=0 -> first `frame_sync` 1 cycle after release; `mux[3]` = 1,1,0,0 for 4 cycles each; period 16.
- Write ch 5 mode 11 in mid-frame -> `cfg_ready` low until the boundary; `mux[5]` = 1 from the next frame start; the other channels are unchanged.
- Write coincident with a boundary edge (ch 2 mode 10) -> `mux[2]` = 0 throughout that same frame; `cfg_ready` never drops.
- Write with `cfg_ch`=20 -> `cfg_err` pulses for 1 cycle; all modes are unchanged.
- Pass mode, toggle `da[0]` every cycle -> `mux[0]` follows with 1-cycle latency; with `MUX_INPUT_FILTER_EN`, a 1-cycle pulse is suppressed and a 3-cycle pulse appears after 4 cycles.
- Assert `rst` during slot 2 with a write pending -> next cycle `mux` = 0 and modes = MODE_RST; the pending write is lost and no `cfg_err` is raised.
